packet_receiver: RTL and testbench
==================================

PACKET_RECEIVER -- requirements
Module: packet_receiver

Interface
REQ-001 SHALL have parameter UWIDTH, default 8: byte width of the packet stream and FIFO data.
REQ-002 SHALL have parameter PTR_IN_SZ, default 4: FIFO intra-packet byte address width; maximum packet length is MAXLEN = 2^PTR_IN_SZ bytes.
REQ-003 SHALL have port clk, input, 1: single clock; all logic on rising edge.
REQ-004 SHALL have port rst, input, 1: synchronous, active-high reset.
REQ-005 SHALL have port packet_valid, input, 1: packet_in carries a valid byte this cycle.
REQ-006 SHALL have port packet_in, input, UWIDTH: packet byte stream in order src_id, dest_id, size, size data bytes, crc.
REQ-007 SHALL have port in_ready, output, 1: a byte is accepted only on cycles with packet_valid && in_ready.
REQ-008 SHALL have port wfull, input, 1: FIFO write-side full flag.
REQ-009 SHALL have port winc, output, 1: one-cycle packet commit strobe to the FIFO.
REQ-010 SHALL have port waddr_in, output, PTR_IN_SZ: byte index within the packet being written.
REQ-011 SHALL have port wdata, output, UWIDTH: byte being written at waddr_in.
REQ-012 SHALL have port crc_err, output, 1: one-cycle pulse, packet dropped for CRC mismatch.
REQ-013 SHALL have port len_err, output, 1: one-cycle pulse, packet dropped because size > MAXLEN-4.

Function
REQ-014 SHALL implement states IDLE, HDR, SIZE, DATA, CRC, DROP.
REQ-015 IDLE: in_ready = !wfull; an accepted byte is src_id at index 0 -> HDR.
REQ-016 HDR: accepted byte is dest_id at index 1 -> SIZE.
REQ-017 SIZE: accepted byte at index 2 latched as dsz; dsz=0 -> CRC; 1 <= dsz <= MAXLEN-4 -> DATA; dsz > MAXLEN-4 -> DROP, len_err pulses next cycle.
REQ-018 DATA: each accepted byte at indices 3..dsz+2, internal down-counter; after the dsz-th byte -> CRC.
REQ-019 CRC: accepted byte at index dsz+3 is crc; -> IDLE.
REQ-020 DROP: in_ready=1; consumes and discards exactly dsz+1 further bytes (data + crc) with no FIFO writes, then -> IDLE.
REQ-021 Outside IDLE, in_ready SHALL be 1; wfull is sampled only in IDLE (FIFO cannot fill without this block's winc).
REQ-022 Every accepted byte outside DROP SHALL appear on wdata with its index on waddr_in exactly 1 cycle after acceptance (registered outputs); waddr_in/wdata hold their last values otherwise.
REQ-023 winc SHALL pulse for exactly 1 cycle, coincident with the crc byte on wdata/waddr_in, when the packet is committed.
REQ-024 Running crc = XOR of src_id, dest_id, size and all data bytes, UWIDTH wide, cleared on entry to HDR path (src_id loaded directly).
REQ-025 packet_valid low in any state SHALL stall: no state, counter or output change except winc/error pulses return to 0.
REQ-026 Back-to-back packets: src_id of the next packet SHALL be acceptable in the cycle immediately after the crc byte if wfull=0.
REQ-027 At most one of winc, crc_err, len_err SHALL be high in any cycle.

Reset
REQ-028 rst=1 at a clock edge SHALL force IDLE, winc=0, crc_err=0, len_err=0, waddr_in=0, wdata=0, dsz=0, crc=0; in_ready=0 during reset.
REQ-029 Reset mid-packet SHALL discard the partial packet with no winc; the staged FIFO bytes are overwritten by the next packet.

Configuration
REQ-030 Macro PKT_CRC_CHECK_EN defined: winc pulses only if received crc equals computed crc; on mismatch winc=0 and crc_err pulses in the same cycle winc would have.
REQ-031 PKT_CRC_CHECK_EN undefined: no crc comparison logic; every completed packet commits with winc; crc_err tied 0.

Verification
REQ-032 Packet 10,160,2,1,2,171 (crc=XOR) with wfull=0 -> waddr_in 0..5, wdata matches, winc high with waddr_in=5, wdata=171.
REQ-033 With PKT_CRC_CHECK_EN, packet 10,160,3,0,1,2,15 -> no winc, crc_err 1-cycle pulse; without the macro -> winc with waddr_in=6.
REQ-034 size=13 (PTR_IN_SZ=4) -> len_err pulse, 14 following bytes consumed, no writes, next packet accepted normally.
REQ-035 wfull=1 in IDLE -> in_ready=0, no bytes accepted; wfull drops -> first byte accepted next cycle.
REQ-036 packet_valid gaps of 3 cycles inside DATA and back-to-back packets -> identical write sequence to gapless case; rst mid-DATA -> no winc, IDLE next cycle.

Source files
------------

// File: rtl/packet_receiver.sv
// packet_receiver: parses a byte stream (src_id, dest_id, size, data..., crc)
// and stages each byte into a packet FIFO at its in-packet index. The packet is
// committed with a single winc strobe coincident with the crc byte. Oversized
// packets are drained without writes and flagged with len_err.
//
// Optional feature macro: PKT_CRC_CHECK_EN
//   defined   -> received crc is compared with the running XOR; mismatching
//                packets are not committed and crc_err pulses instead of winc.
//   undefined -> every completed packet commits; crc_err is tied low.
module packet_receiver #(
    parameter int UWIDTH    = 8,
    parameter int PTR_IN_SZ = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 packet_valid,
    input  logic [UWIDTH-1:0]    packet_in,
    output logic                 in_ready,
    input  logic                 wfull,
    output logic                 winc,
    output logic [PTR_IN_SZ-1:0] waddr_in,
    output logic [UWIDTH-1:0]    wdata,
    output logic                 crc_err,
    output logic                 len_err
);

    localparam int unsigned     MAXLEN  = 1 << PTR_IN_SZ;
    // Largest data length that still fits with the 4 framing bytes.
    localparam logic [UWIDTH:0] MAX_DSZ = (UWIDTH + 1)'(MAXLEN - 4);
    localparam logic [UWIDTH:0] CNT_ONE = (UWIDTH + 1)'(1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR,
        S_SIZE,
        S_DATA,
        S_CRC,
        S_DROP
    } state_t;

    state_t                 state_q, state_d;
    logic [UWIDTH-1:0]      dsz_q, dsz_d;
    // Remaining bytes in DATA (data only) or DROP (data + crc); one bit wider
    // than a byte so a dropped packet of size 2^UWIDTH-1 can count crc too.
    logic [UWIDTH:0]        cnt_q, cnt_d;
    logic [UWIDTH-1:0]      crc_q, crc_d;
    logic [PTR_IN_SZ-1:0]   waddr_q, waddr_d;
    logic [UWIDTH-1:0]      wdata_q, wdata_d;
    logic                   winc_q, winc_d;
    logic                   len_err_q, len_err_d;
    logic                   accept;

    // Handshake: wfull only gates the first byte of a packet; held low in reset.
    always_comb begin
        if (rst) begin
            in_ready = 1'b0;
        end else if (state_q == S_IDLE) begin
            in_ready = !wfull;
        end else begin
            in_ready = 1'b1;
        end
    end

    assign accept = packet_valid && in_ready;

`ifdef PKT_CRC_CHECK_EN
    logic crc_err_q, crc_err_d;
`endif

    // Next-state, byte staging, running crc and one-cycle status pulses.
    always_comb begin
        state_d   = state_q;
        dsz_d     = dsz_q;
        cnt_d     = cnt_q;
        crc_d     = crc_q;
        waddr_d   = waddr_q;
        wdata_d   = wdata_q;
        winc_d    = 1'b0;
        len_err_d = 1'b0;
`ifdef PKT_CRC_CHECK_EN
        crc_err_d = 1'b0;
`endif
        if (accept) begin
            // Every byte outside DROP is staged at the next in-packet index;
            // waddr restarts at 0 on the src_id byte.
            if (state_q != S_DROP) begin
                wdata_d = packet_in;
                waddr_d = (state_q == S_IDLE) ? '0 : waddr_q + 1'b1;
            end
            case (state_q)
                S_IDLE: begin
                    crc_d   = packet_in;
                    state_d = S_HDR;
                end
                S_HDR: begin
                    crc_d   = crc_q ^ packet_in;
                    state_d = S_SIZE;
                end
                S_SIZE: begin
                    crc_d = crc_q ^ packet_in;
                    dsz_d = packet_in;
                    if (packet_in == '0) begin
                        state_d = S_CRC;
                    end else if ({1'b0, packet_in} > MAX_DSZ) begin
                        state_d   = S_DROP;
                        len_err_d = 1'b1;
                        cnt_d     = {1'b0, packet_in} + 1'b1;
                    end else begin
                        state_d = S_DATA;
                        cnt_d   = {1'b0, packet_in};
                    end
                end
                S_DATA: begin
                    crc_d = crc_q ^ packet_in;
                    cnt_d = cnt_q - 1'b1;
                    if (cnt_q == CNT_ONE) begin
                        state_d = S_CRC;
                    end
                end
                S_CRC: begin
                    state_d = S_IDLE;
`ifdef PKT_CRC_CHECK_EN
                    if (packet_in == crc_q) begin
                        winc_d = 1'b1;
                    end else begin
                        crc_err_d = 1'b1;
                    end
`else
                    winc_d = 1'b1;
`endif
                end
                S_DROP: begin
                    cnt_d = cnt_q - 1'b1;
                    if (cnt_q == CNT_ONE) begin
                        state_d = S_IDLE;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            dsz_q     <= '0;
            cnt_q     <= '0;
            crc_q     <= '0;
            waddr_q   <= '0;
            wdata_q   <= '0;
            winc_q    <= 1'b0;
            len_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            dsz_q     <= dsz_d;
            cnt_q     <= cnt_d;
            crc_q     <= crc_d;
            waddr_q   <= waddr_d;
            wdata_q   <= wdata_d;
            winc_q    <= winc_d;
            len_err_q <= len_err_d;
        end
    end

`ifdef PKT_CRC_CHECK_EN
    // CRC mismatch pulse register.
    always_ff @(posedge clk) begin
        if (rst) begin
            crc_err_q <= 1'b0;
        end else begin
            crc_err_q <= crc_err_d;
        end
    end

    assign crc_err = crc_err_q;
`else
    assign crc_err = 1'b0;
`endif

    assign winc     = winc_q;
    assign waddr_in = waddr_q;
    assign wdata    = wdata_q;
    assign len_err  = len_err_q;

endmodule

// File: tb/tb_packet_receiver.sv
// tb_packet_receiver: randomized packets (good, bad-crc, oversized) with random
// valid gaps and wfull noise, checked against a packet-level reference model.
module tb_packet_receiver;

    localparam int UW     = 8;
    localparam int PW     = 4;
    localparam int MAXLEN = 1 << PW;
`ifdef PKT_CRC_CHECK_EN
    localparam bit CRC_EN = 1'b1;
`else
    localparam bit CRC_EN = 1'b0;
`endif

    typedef logic [UW-1:0] byte_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          packet_valid;
    logic [UW-1:0] packet_in;
    logic          in_ready;
    logic          wfull;
    logic          winc;
    logic [PW-1:0] waddr_in;
    logic [UW-1:0] wdata;
    logic          crc_err;
    logic          len_err;

    int unsigned   n_tests = 0;
    int unsigned   n_fail  = 0;

    // Model of the last staged FIFO location (held between writes).
    logic [PW-1:0] exp_waddr;
    byte_t         exp_wdata;
    byte_t         pkt[$];

    always #5 clk = ~clk;

    packet_receiver #(.UWIDTH(UW), .PTR_IN_SZ(PW)) dut (
        .clk          (clk),
        .rst          (rst),
        .packet_valid (packet_valid),
        .packet_in    (packet_in),
        .in_ready     (in_ready),
        .wfull        (wfull),
        .winc         (winc),
        .waddr_in     (waddr_in),
        .wdata        (wdata),
        .crc_err      (crc_err),
        .len_err      (len_err)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Hold packet_valid low; outputs must hold and pulses stay low.
    task automatic idle_cycles(input int n);
        packet_valid = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
            check("gap_winc", winc, 0);
            check("gap_crc_err", crc_err, 0);
            check("gap_len_err", len_err, 0);
            check("gap_waddr", waddr_in, exp_waddr);
            check("gap_wdata", wdata, exp_wdata);
        end
    endtask

    // Present one byte, expect it to be taken at the next edge, then check
    // the registered outputs one cycle after acceptance.
    task automatic send_byte(input byte_t b, input bit first, input bit wr,
                             input logic [PW-1:0] idx, input bit e_winc,
                             input bit e_cerr, input bit e_lerr);
        packet_valid = 1'b1;
        packet_in    = b;
        wfull        = first ? 1'b0 : 1'($urandom_range(0, 1));
        @(negedge clk);
        check("in_ready", in_ready, 1);
        @(posedge clk);
        #1;
        packet_valid = 1'b0;
        wfull        = 1'b0;
        if (wr) begin
            exp_waddr = idx;
            exp_wdata = b;
        end
        check("waddr", waddr_in, exp_waddr);
        check("wdata", wdata, exp_wdata);
        check("winc", winc, e_winc);
        check("crc_err", crc_err, e_cerr);
        check("len_err", len_err, e_lerr);
    endtask

    // Reference: header bytes and (for legal sizes) data and crc are staged
    // at their position; oversized packets stage only the header and raise
    // len_err after the size byte; the last byte of a legal packet commits
    // unless crc checking is on and it differs from the XOR of the rest.
    task automatic send_packet(input int max_gap);
        int    n;
        int    dsz;
        bit    drop;
        byte_t x;
        n    = pkt.size();
        dsz  = int'(pkt[2]);
        drop = dsz > MAXLEN - 4;
        x    = '0;
        for (int i = 0; i < n - 1; i++) x ^= pkt[i];
        for (int i = 0; i < n; i++) begin
            bit last;
            bit match;
            last  = !drop && (i == n - 1);
            match = (pkt[i] == x);
            send_byte(pkt[i], i == 0, !drop || i <= 2, PW'(i),
                      last && (!CRC_EN || match),
                      last && CRC_EN && !match,
                      drop && i == 2);
            if (max_gap > 0 && $urandom_range(0, 3) == 0)
                idle_cycles(int'($urandom_range(1, max_gap)));
        end
    endtask

    task automatic make_packet(input int dsz, input bit bad_crc);
        byte_t x;
        pkt = {};
        pkt.push_back(byte_t'($urandom));
        pkt.push_back(byte_t'($urandom));
        pkt.push_back(byte_t'(dsz));
        for (int i = 0; i < dsz; i++) pkt.push_back(byte_t'($urandom));
        x = '0;
        foreach (pkt[i]) x ^= pkt[i];
        if (bad_crc) x ^= byte_t'($urandom_range(1, 255));
        pkt.push_back(x);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        rst          = 1'b1;
        packet_valid = 1'b0;
        wfull        = 1'b0;
        packet_in    = '0;
        exp_waddr    = '0;
        exp_wdata    = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready", in_ready, 0);
        check("rst_winc", winc, 0);
        check("rst_waddr", waddr_in, 0);
        check("rst_wdata", wdata, 0);
        check("rst_crc_err", crc_err, 0);
        check("rst_len_err", len_err, 0);
        rst = 1'b0;
        #1;
        check("post_rst_in_ready", in_ready, 1);

        // Reference packet with correct crc.
        pkt = '{8'd10, 8'd160, 8'd2, 8'd1, 8'd2, 8'd171};
        send_packet(0);
        // Reference packet with wrong crc, sent back-to-back.
        pkt = '{8'd10, 8'd160, 8'd3, 8'd0, 8'd1, 8'd2, 8'd15};
        send_packet(0);
        // Oversized packet followed immediately by a normal one.
        make_packet(13, 1'b0);
        send_packet(0);
        make_packet(4, 1'b0);
        send_packet(0);
        // Zero-length and maximum-length packets.
        make_packet(0, 1'b0);
        send_packet(3);
        make_packet(MAXLEN - 4, 1'b0);
        send_packet(3);

        // wfull in IDLE blocks the first byte until it drops.
        make_packet(3, 1'b0);
        wfull        = 1'b1;
        packet_valid = 1'b1;
        packet_in    = pkt[0];
        repeat (3) begin
            @(negedge clk);
            check("wfull_in_ready", in_ready, 0);
            @(posedge clk);
            #1;
            check("wfull_waddr", waddr_in, exp_waddr);
            check("wfull_wdata", wdata, exp_wdata);
            check("wfull_winc", winc, 0);
        end
        send_packet(0);

        // Randomized traffic.
        for (int p = 0; p < 150; p++) begin
            int kind;
            kind = int'($urandom_range(0, 9));
            if (kind < 2)
                make_packet(int'($urandom_range(MAXLEN - 3, 30)), 1'b0);
            else
                make_packet(int'($urandom_range(0, MAXLEN - 4)), kind < 4);
            send_packet(($urandom_range(0, 1) == 1) ? 3 : 0);
        end

        // Reset in the middle of DATA discards the packet.
        make_packet(6, 1'b0);
        for (int i = 0; i < 5; i++)
            send_byte(pkt[i], i == 0, 1'b1, PW'(i), 1'b0, 1'b0, 1'b0);
        rst          = 1'b1;
        packet_valid = 1'b1;
        packet_in    = pkt[5];
        @(posedge clk);
        #1;
        exp_waddr = '0;
        exp_wdata = '0;
        check("midrst_in_ready", in_ready, 0);
        check("midrst_winc", winc, 0);
        check("midrst_waddr", waddr_in, 0);
        check("midrst_wdata", wdata, 0);
        rst          = 1'b0;
        packet_valid = 1'b0;
        #1;
        check("midrst_idle_in_ready", in_ready, 1);
        idle_cycles(1);
        make_packet(5, 1'b0);
        send_packet(0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
